hpdl1414_scan: RTL and testbench
================================

// Module: hpdl1414_scan
// PURPOSE
//  Reader side of the 16-char display buffer. Sweeps buffer addresses 0..15 at a fixed refresh rate.
//  Drives each character into four HPDL-1414 4-digit displays using a bus-write timing sequence.
//  Periodic rewrite is what makes the buffer's caret blink visible on the displays.
//  Sits between the display buffer read port and the top-level HPDL-1414 pins.
// PARAMETERS
//  REFRESH_DIV  250000  clocks between sweep-start ticks; must exceed 16*(2+SETUP_CYC+WR_CYC+HOLD_CYC)
//  SETUP_CYC    2       clocks addr/data stable with WR high before strobe (>=1)
//  WR_CYC       4       clocks WR held low (>=1)
//  HOLD_CYC     2       clocks addr/data held after WR rises (>=1)
// PORTS
//  i_clk         in   1  system clock
//  i_rst         in   1  synchronous reset, active-high
//  i_enable      in   1  1 = sweeps allowed; sampled only when idle
//  o_rd_en       out  1  buffer read enable, one-cycle pulse
//  o_rd_addr     out  4  buffer read address
//  i_rd_data     in   8  buffer read data, valid 1 clock after o_rd_en
//  o_disp_wr_n   out  4  per-display WR strobe, active-low; bit d = display d
//  o_disp_addr   out  2  HPDL-1414 digit address A1:A0
//  o_disp_data   out  7  HPDL-1414 data D6:D0
//  o_busy        out  1  high while a sweep is in progress
//  o_frame_done  out  1  one-cycle pulse after char 15 HOLD completes
// BEHAVIOUR
//  Reset values: o_disp_wr_n=4'hF, o_rd_en=0, o_rd_addr=0, o_disp_addr=0, o_disp_data=7'h20.
//   Also o_busy=0, o_frame_done=0, refresh counter=0, char index=0, state=IDLE.
//  Reset mid-operation: all outputs take reset values on the next edge.
//   A WR low in progress is released immediately; the partial sweep is abandoned.
//  Refresh counter: free-runs 0..REFRESH_DIV-1 and wraps. Tick = (count==REFRESH_DIV-1).
//   A tick while not IDLE, or with i_enable=0, is dropped, never queued.
//  FSM (registered outputs):
//   IDLE   : on tick && i_enable -> READ with index=0; o_busy=1.
//   READ   : o_rd_en=1, o_rd_addr=index for exactly 1 clock -> WAIT.
//   WAIT   : o_rd_en=0; capture mapped i_rd_data into o_disp_data.
//            Set o_disp_addr=3-index[1:0] -> SETUP.
//   SETUP  : o_disp_wr_n all high for SETUP_CYC clocks -> STROBE.
//   STROBE : o_disp_wr_n[index[3:2]]=0 (only that bit) for WR_CYC clocks -> HOLD.
//   HOLD   : all WR high, addr/data unchanged, for HOLD_CYC clocks.
//            If index==15: o_frame_done=1, o_busy=0 -> IDLE.
//            Otherwise: index+1 -> READ.
//  Mapping: buffer address k goes to display k/4, digit 3-(k%4). Address 0 is the leftmost digit of display 0.
//  Character map from byte b to 7-bit data:
//   b in 0x20..0x5F -> b[6:0]
//   b in 0x60..0x7F -> b-0x20 (lowercase folded to uppercase)
//   otherwise -> 0x20 (space)
//  Caret substitution happens upstream. This block writes whatever byte it reads.
//  Per-char latency: 2+SETUP_CYC+WR_CYC+HOLD_CYC clocks (10 at defaults). Sweep = 160 clocks at defaults.
//  o_disp_addr/o_disp_data change only in WAIT. They never change while any WR bit is low.
//  At most one o_disp_wr_n bit is low at any time.
//  o_busy rises 1 clock after the tick and falls in the same clock as o_frame_done.
// TESTING (REFRESH_DIV=200, defaults otherwise; behavioural buffer model with 1-cycle read latency)
//  1. Buffer = "HELLO WORLD 1234", enable=1.
//     -> 16 WR pulses of 4 clocks each, spaced 10 clocks apart.
//     -> Display 0 digits 3..0 = 'H','E','L','L'; display 3 digit 0 = '4'.
//     -> o_frame_done pulses once, 160 clocks after sweep start.
//  2. Buffer bytes 0x61, 0x1B, 0x80, 0x5F at addresses 0..3.
//     -> Display 0 receives 0x41, 0x20, 0x20, 0x5F on digits 3, 2, 1, 0.
//  3. Protocol checker over full sweep:
//     -> Addr/data stable from 2 clocks before each WR fall to 2 clocks after its rise.
//     -> Never two WR bits low at once.
//     -> o_rd_en is high for exactly 16 single clocks per sweep.
//  4. i_enable=0 across two ticks -> no o_rd_en, o_disp_wr_n stays 4'hF, o_busy stays 0.
//     Then raise i_enable -> sweep starts at the next tick only.
//  5. Assert i_rst for 1 clock during the STROBE of char 5.
//     -> Next edge: o_disp_wr_n=4'hF, o_busy=0, o_disp_data=7'h20.
//     -> The next sweep restarts from address 0.
//  6. Change buffer[7] between two sweeps.
//     -> The second sweep writes the new value to display 1, digit 0; all other writes are unchanged.

Source files
------------

// File: rtl/hpdl1414_scan.sv
// hpdl1414_scan: sweeps the 16-char display buffer and replays each
// character into four HPDL-1414 displays with a timed WR strobe.
module hpdl1414_scan #(
  parameter int REFRESH_DIV = 250000,
  parameter int SETUP_CYC   = 2,
  parameter int WR_CYC      = 4,
  parameter int HOLD_CYC    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  output logic       o_rd_en,
  output logic [3:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic [3:0] o_disp_wr_n,
  output logic [1:0] o_disp_addr,
  output logic [6:0] o_disp_data,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int PM_SW = (SETUP_CYC > WR_CYC) ? SETUP_CYC : WR_CYC;
  localparam int PMAX  = (PM_SW > HOLD_CYC) ? PM_SW : HOLD_CYC;
  localparam int CW = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] SU_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] HD_LAST  = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [3:0]    idx;
  logic [3:0]    idx_n;
  logic [CW-1:0] cyc;
  logic [RW-1:0] ref_cnt;
  logic          tick;

  logic          rd_en_n;
  logic [3:0]    wr_n_n;
  logic          busy_n;
  logic          done_n;

  // Fold lowercase onto uppercase; anything outside the glyph set is a space.
  function automatic logic [6:0] char_map(input logic [7:0] b);
    logic [6:0] r;
    r = 7'h20;
    unique case (1'b1)
      (!b[7] && (b[6:5] == 2'b11)): r = {2'b10, b[4:0]};
      (!b[7] && (b[6] ^ b[5])):     r = b[6:0];
      default:                      r = 7'h20;
    endcase
    return r;
  endfunction

  assign tick = (ref_cnt == REF_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ref_cnt <= '0;
    end else if (tick) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      idx   <= '0;
      cyc   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cyc   <= (state_n != state) ? '0 : cyc + CW'(1);
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        if (tick && i_enable) begin
          state_n = READ;
          idx_n   = '0;
        end
      end
      READ: state_n = WAIT;
      WAIT: state_n = SETUP;
      SETUP: begin
        if (cyc == SU_LAST) state_n = STROBE;
      end
      STROBE: begin
        if (cyc == WR_LAST) state_n = HOLD;
      end
      HOLD: begin
        if (cyc == HD_LAST) begin
          if (idx == 4'd15) begin
            state_n = IDLE;
          end else begin
            state_n = READ;
            idx_n   = idx + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output values for the next cycle, so every pin comes straight off a flop.
  always_comb begin
    rd_en_n = (state_n == READ);
    busy_n  = (state_n != IDLE);
    done_n  = (state == HOLD) && (state_n == IDLE);
    wr_n_n  = 4'hF;
    if (state_n == STROBE) wr_n_n[idx_n[3:2]] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_en      <= 1'b0;
      o_rd_addr    <= '0;
      o_disp_wr_n  <= 4'hF;
      o_disp_addr  <= '0;
      o_disp_data  <= 7'h20;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_rd_en      <= rd_en_n;
      o_disp_wr_n  <= wr_n_n;
      o_busy       <= busy_n;
      o_frame_done <= done_n;
      if (state_n == READ) o_rd_addr <= idx_n;
      if (state == WAIT) begin
        o_disp_data <= char_map(i_rd_data);
        o_disp_addr <= 2'd3 - idx[1:0];
      end
    end
  end

endmodule

// File: tb/tb_hpdl1414_scan.sv
// Directed bench for hpdl1414_scan: sweeps a modelled buffer and
// records every WR pulse plus bus-protocol violations.
module tb_hpdl1414_scan;

  localparam int RDIV = 200;

  logic       i_clk;
  logic       i_rst;
  logic       i_enable;
  logic       o_rd_en;
  logic [3:0] o_rd_addr;
  logic [7:0] i_rd_data;
  logic [3:0] o_disp_wr_n;
  logic [1:0] o_disp_addr;
  logic [6:0] o_disp_data;
  logic       o_busy;
  logic       o_frame_done;

  int n_checks;
  int n_fail;

  logic [7:0] bufm [16];
  int         ref_model;

  int         cap_n;
  int         cap_viol;
  int         cap_rden;
  int         cap_done_n;
  int         cap_done_c;
  int         cap_to;
  int         cap_fall [16];
  int         cap_w    [16];
  int         cap_disp [16];
  logic [1:0] cap_addr [16];
  logic [6:0] cap_data [16];

  hpdl1414_scan #(
    .REFRESH_DIV(RDIV),
    .SETUP_CYC  (2),
    .WR_CYC     (4),
    .HOLD_CYC   (2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_enable    (i_enable),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_disp_wr_n (o_disp_wr_n),
    .o_disp_addr (o_disp_addr),
    .o_disp_data (o_disp_data),
    .o_busy      (o_busy),
    .o_frame_done(o_frame_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Display buffer with one clock of read latency.
  always @(posedge i_clk) begin
    if (o_rd_en) i_rd_data <= bufm[o_rd_addr];
  end

  always @(posedge i_clk) begin
    if (i_rst) ref_model <= 0;
    else ref_model <= (ref_model == RDIV - 1) ? 0 : ref_model + 1;
  end

  function automatic logic [6:0] tb_map(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h5F) return b[6:0];
    if (b >= 8'h60 && b <= 8'h7F) return 7'(b - 8'h20);
    return 7'h20;
  endfunction

  task automatic load_str(input string s);
    for (int i = 0; i < 16; i++) bufm[i] = s[i];
  endtask

  task automatic capture_sweep();
    int c;
    int last_chg;
    int last_rise;
    int cur;
    logic [3:0] pwr;
    logic [8:0] pad;
    logic [8:0] ad;
    logic prd;
    cap_n = 0;
    cap_viol = 0;
    cap_rden = 0;
    cap_done_n = 0;
    cap_done_c = -1;
    cap_to = 0;
    for (int i = 0; i < 16; i++) begin
      cap_fall[i] = -1;
      cap_w[i] = 0;
      cap_disp[i] = -1;
      cap_addr[i] = '0;
      cap_data[i] = '0;
    end
    c = 0;
    while (!o_busy && c < 2 * RDIV + 100) begin
      @(negedge i_clk);
      c++;
    end
    if (!o_busy) begin
      cap_to = 1;
      return;
    end
    pwr = 4'hF;
    pad = {o_disp_addr, o_disp_data};
    last_chg = -100;
    last_rise = -100;
    prd = 1'b0;
    cur = -1;
    for (int k = 0; k < 170; k++) begin
      ad = {o_disp_addr, o_disp_data};
      if (ad != pad) begin
        if (o_disp_wr_n != 4'hF || k < last_rise + 2) cap_viol++;
        last_chg = k;
      end
      if ($countones(~o_disp_wr_n) > 1) cap_viol++;
      if (o_disp_wr_n != 4'hF && pwr == 4'hF) begin
        if (k - last_chg < 2) cap_viol++;
        cur = cap_n;
        if (cap_n < 16) begin
          cap_fall[cap_n] = k;
          for (int b = 0; b < 4; b++)
            if (!o_disp_wr_n[b]) cap_disp[cap_n] = b;
          cap_addr[cap_n] = o_disp_addr;
          cap_data[cap_n] = o_disp_data;
        end
        cap_n++;
      end
      if (o_disp_wr_n != 4'hF && cur >= 0 && cur < 16) cap_w[cur]++;
      if (o_disp_wr_n == 4'hF && pwr != 4'hF) last_rise = k;
      if (o_rd_en) begin
        cap_rden++;
        if (prd) cap_viol++;
      end
      if (o_frame_done) begin
        cap_done_n++;
        cap_done_c = k;
      end
      prd = o_rd_en;
      pwr = o_disp_wr_n;
      pad = ad;
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_enable = 1'b0;
    for (int i = 0; i < 16; i++) bufm[i] = 8'h20;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if (o_disp_wr_n !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_wr_n got=%h exp=f", o_disp_wr_n);
    end
    n_checks++;
    if (o_rd_en !== 1'b0 || o_rd_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_rd got=%b/%h exp=0/0", o_rd_en, o_rd_addr);
    end
    n_checks++;
    if (o_disp_addr !== 2'd0 || o_disp_data !== 7'h20) begin
      n_fail++;
      $display("FAIL reset_disp got=%h/%h exp=0/20", o_disp_addr, o_disp_data);
    end
    n_checks++;
    if (o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got=%b/%b exp=0/0", o_busy, o_frame_done);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_hello();
    int bad;
    load_str("HELLO WORLD 1234");
    i_enable = 1'b1;
    capture_sweep();
    n_checks++;
    if (cap_to !== 0 || cap_n !== 16) begin
      n_fail++;
      $display("FAIL hello_pulses got=%0d to=%0d exp=16", cap_n, cap_to);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (cap_w[i] != 4) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hello_width bad=%0d w0=%0d exp=4", bad, cap_w[0]);
    end
    n_checks++;
    if (cap_fall[0] !== 4) begin
      n_fail++;
      $display("FAIL hello_first_fall got=%0d exp=4", cap_fall[0]);
    end
    bad = 0;
    for (int i = 1; i < 16; i++) if (cap_fall[i] - cap_fall[i-1] != 10) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hello_spacing bad=%0d exp=0", bad);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (cap_disp[i] !== i / 4 || cap_addr[i] !== 2'(3 - i % 4) ||
          cap_data[i] !== tb_map(bufm[i])) begin
        n_fail++;
        $display("FAIL hello_char%0d got=d%0d a%0d %h exp=d%0d a%0d %h", i,
                 cap_disp[i], cap_addr[i], cap_data[i], i / 4, 3 - i % 4,
                 tb_map(bufm[i]));
      end
    end
    n_checks++;
    if (cap_addr[0] !== 2'd3 || cap_data[0] !== 7'h48 || cap_data[3] !== 7'h4C) begin
      n_fail++;
      $display("FAIL hello_disp0 got=%h %h exp=48 4c", cap_data[0], cap_data[3]);
    end
    n_checks++;
    if (cap_disp[15] !== 3 || cap_addr[15] !== 2'd0 || cap_data[15] !== 7'h34) begin
      n_fail++;
      $display("FAIL hello_d3d0 got=%h exp=34", cap_data[15]);
    end
    n_checks++;
    if (cap_done_n !== 1 || cap_done_c !== 160) begin
      n_fail++;
      $display("FAIL hello_frame_done got=n%0d c%0d exp=n1 c160", cap_done_n, cap_done_c);
    end
  endtask

  task automatic test_map();
    logic [7:0] bin [10] = '{8'h61, 8'h1B, 8'h80, 8'h5F, 8'h7F,
                             8'h60, 8'h20, 8'h1F, 8'hFF, 8'h41};
    logic [6:0] exp [10] = '{7'h41, 7'h20, 7'h20, 7'h5F, 7'h5F,
                             7'h40, 7'h20, 7'h20, 7'h20, 7'h41};
    for (int i = 0; i < 16; i++) bufm[i] = 8'h30 + 8'(i);
    for (int i = 0; i < 10; i++) bufm[i] = bin[i];
    capture_sweep();
    n_checks++;
    if (cap_to !== 0 || cap_n !== 16) begin
      n_fail++;
      $display("FAIL map_pulses got=%0d exp=16", cap_n);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (cap_data[i] !== exp[i] || cap_addr[i] !== 2'(3 - i % 4)) begin
        n_fail++;
        $display("FAIL map_byte%0d in=%h got=%h exp=%h", i, bin[i], cap_data[i], exp[i]);
      end
    end
  endtask

  task automatic test_protocol();
    load_str("abcdefghijklmnop");
    capture_sweep();
    n_checks++;
    if (cap_to !== 0 || cap_viol !== 0) begin
      n_fail++;
      $display("FAIL protocol_viol got=%0d to=%0d exp=0", cap_viol, cap_to);
    end
    n_checks++;
    if (cap_rden !== 16) begin
      n_fail++;
      $display("FAIL protocol_rd_en got=%0d exp=16", cap_rden);
    end
    n_checks++;
    if (cap_data[2] !== 7'h43) begin
      n_fail++;
      $display("FAIL protocol_fold got=%h exp=43", cap_data[2]);
    end
  endtask

  task automatic test_disable();
    int bad_rd;
    int bad_wr;
    int bad_bsy;
    int v;
    int n;
    i_enable = 1'b0;
    bad_rd = 0;
    bad_wr = 0;
    bad_bsy = 0;
    for (int k = 0; k < 2 * RDIV + 50; k++) begin
      @(negedge i_clk);
      if (o_rd_en) bad_rd++;
      if (o_disp_wr_n != 4'hF) bad_wr++;
      if (o_busy) bad_bsy++;
    end
    n_checks++;
    if (bad_rd !== 0) begin
      n_fail++;
      $display("FAIL disable_rd_en got=%0d exp=0", bad_rd);
    end
    n_checks++;
    if (bad_wr !== 0) begin
      n_fail++;
      $display("FAIL disable_wr_n got=%0d exp=0", bad_wr);
    end
    n_checks++;
    if (bad_bsy !== 0) begin
      n_fail++;
      $display("FAIL disable_busy got=%0d exp=0", bad_bsy);
    end
    v = ref_model;
    i_enable = 1'b1;
    n = 0;
    while (!o_busy && n < 2 * RDIV) begin
      @(negedge i_clk);
      n++;
    end
    n_checks++;
    if (n !== RDIV - v) begin
      n_fail++;
      $display("FAIL enable_start got=%0d exp=%0d", n, RDIV - v);
    end
    n = 0;
    while (!o_frame_done && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    n_checks++;
    if (!o_frame_done) begin
      n_fail++;
      $display("FAIL enable_sweep_end got=timeout exp=frame_done");
    end
  endtask

  task automatic test_reset_mid();
    int n;
    load_str("ABCDEFGHIJKLMNOP");
    n = 0;
    while (!o_busy && n < 2 * RDIV + 100) begin
      @(negedge i_clk);
      n++;
    end
    repeat (55) @(negedge i_clk);
    n_checks++;
    if (o_disp_wr_n !== 4'b1101) begin
      n_fail++;
      $display("FAIL rstmid_strobe got=%b exp=1101", o_disp_wr_n);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_disp_wr_n !== 4'hF || o_busy !== 1'b0 || o_disp_data !== 7'h20) begin
      n_fail++;
      $display("FAIL rstmid_outputs got=%h %b %h exp=f 0 20",
               o_disp_wr_n, o_busy, o_disp_data);
    end
    n_checks++;
    if (o_rd_en !== 1'b0 || o_rd_addr !== 4'd0 || o_disp_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_rd got=%b %h %h exp=0 0 0", o_rd_en, o_rd_addr, o_disp_addr);
    end
    i_rst = 1'b0;
    capture_sweep();
    n_checks++;
    if (cap_to !== 0 || cap_n !== 16 || cap_disp[0] !== 0 ||
        cap_addr[0] !== 2'd3 || cap_data[0] !== 7'h41) begin
      n_fail++;
      $display("FAIL rstmid_restart got=n%0d d%0d a%0d %h exp=n16 d0 a3 41",
               cap_n, cap_disp[0], cap_addr[0], cap_data[0]);
    end
  endtask

  task automatic test_update();
    logic [6:0] first [16];
    int bad;
    load_str("0123456789ABCDEF");
    capture_sweep();
    for (int i = 0; i < 16; i++) first[i] = cap_data[i];
    n_checks++;
    if (cap_to !== 0 || first[7] !== 7'h37) begin
      n_fail++;
      $display("FAIL update_before got=%h exp=37", first[7]);
    end
    bufm[7] = "z";
    capture_sweep();
    n_checks++;
    if (cap_disp[7] !== 1 || cap_addr[7] !== 2'd0 || cap_data[7] !== 7'h5A) begin
      n_fail++;
      $display("FAIL update_char7 got=d%0d a%0d %h exp=d1 a0 5a",
               cap_disp[7], cap_addr[7], cap_data[7]);
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (i != 7 && cap_data[i] !== first[i]) bad++;
    n_checks++;
    if (cap_to !== 0 || cap_n !== 16 || bad !== 0) begin
      n_fail++;
      $display("FAIL update_others got=%0d diffs n%0d exp=0 n16", bad, cap_n);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    i_rst = 1'b1;
    i_enable = 1'b0;
    test_reset();
    test_hello();
    test_map();
    test_protocol();
    test_disable();
    test_reset_mid();
    test_update();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
